fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Sequential instruction fetch from an asynchronous-read program ROM into a
// single instruction register (ir) that feeds the decoder.
//
// Ports
//   clk       in   1   single clock; all state updates on the rising edge
//   rst       in   1   synchronous active-high reset
//   rom_addr  out  AW  ROM address, always equal to pc
//   rom_data  in   DW  ROM word at rom_addr, valid in the same cycle
//   ir        out  DW  instruction register presented to the decoder
//   ir_pc     out  AW  address ir was fetched from
//   ir_valid  out  1   ir holds an unconsumed instruction
//   ir_ready  in   1   decoder accepts ir this cycle
//   jmp       in   1   redirect request, sampled every cycle
//   jmp_addr  in   AW  redirect target, sampled with jmp
//   halt      in   1   level request to stop fetching
//   halted    out  1   FSM is in HALTED (this is the state register itself)
//
// Handshake: ir is transferred to the decoder on every rising edge where
// ir_valid && ir_ready. ir_valid, ir and ir_pc never depend combinationally
// on ir_ready; ir_valid only drops because of a transfer, a jmp flush or reset.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int              AW         = 8,
    parameter int              DW         = 9,
    parameter logic [AW-1:0]   START_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] ir,
    output logic [AW-1:0] ir_pc,
    output logic          ir_valid,
    input  logic          ir_ready,
    input  logic          jmp,
    input  logic [AW-1:0] jmp_addr,
    input  logic          halt,
    output logic          halted
);

    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_HALTED = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] pc;
    logic          slot_free;
    logic          consumed;

    // The slot can take a new word when it is empty or being drained now.
    assign slot_free = !ir_valid || ir_ready;
    assign consumed  = ir_valid && ir_ready;

    assign rom_addr  = pc;
    assign halted    = (state == S_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RUN;
            pc       <= START_ADDR;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (jmp) begin
            // Redirect wins over fetch, stall and halt. A coincident transfer
            // still counts as consumed by the decoder; the slot is flushed.
            pc       <= jmp_addr;
            ir_valid <= 1'b0;
            // Leaving HALTED is driven purely by halt; a jump does not
            // unhalt, and in RUN a jump suppresses entering HALTED.
            if (state == S_HALTED && !halt) begin
                state <= S_RUN;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (halt) begin
                        // Stop without fetching; pc already names the next
                        // unfetched word. A pending ir may still drain.
                        state <= S_HALTED;
                        if (consumed) begin
                            ir_valid <= 1'b0;
                        end
                    end else if (slot_free) begin
                        ir       <= rom_data;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        pc       <= pc + AW'(1);   // wraps modulo 2^AW
                    end
                end
                S_HALTED: begin
                    if (consumed) begin
                        ir_valid <= 1'b0;
                    end
                    if (!halt) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit with default parameters (AW=8, DW=9, START_ADDR=0).
// The ROM model returns ROM[i] = i + 0x100. A per-cycle vector table checks
// the visible outputs after each edge; every decoder transfer is checked in
// program order against an expected queue. A random-backpressure run follows.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int AW = 8;
    localparam int DW = 9;

    logic          clk;
    logic          rst;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready;
    logic          jmp;
    logic [AW-1:0] jmp_addr;
    logic          halt;
    logic          halted;

    int n_tests;
    int n_fail;

    logic [AW-1:0] exp_q[$];

    fetch_unit #(.AW(AW), .DW(DW), .START_ADDR(8'h00)) dut (
        .clk      (clk),
        .rst      (rst),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .ir       (ir),
        .ir_pc    (ir_pc),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .jmp      (jmp),
        .jmp_addr (jmp_addr),
        .halt     (halt),
        .halted   (halted)
    );

    // ---------------- clock / ROM ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_data = {1'b1, rom_addr};   // i + 0x100

    // ---------------- vector table ----------------
    typedef struct {
        logic          rst;
        logic          halt;
        logic          jmp;
        logic [AW-1:0] ja;
        logic          rdy;
        logic          e_valid;
        logic [AW-1:0] e_pc;
        logic [AW-1:0] e_rom;
        logic          e_halt;
    } vec_t;

    vec_t vecs[37];

    function automatic vec_t mk(input logic r, input logic h, input logic j,
                                input logic [AW-1:0] ja, input logic rdy,
                                input logic ev, input logic [AW-1:0] ep,
                                input logic [AW-1:0] er, input logic eh);
        vec_t v;
        v.rst = r; v.halt = h; v.jmp = j; v.ja = ja; v.rdy = rdy;
        v.e_valid = ev; v.e_pc = ep; v.e_rom = er; v.e_halt = eh;
        return v;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // One clock: capture any transfer before the edge, then score it.
    task automatic tick();
        logic          xfer;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [AW-1:0] e;
        xfer = ir_valid && ir_ready;
        a    = ir_pc;
        d    = ir;
        @(posedge clk);
        #1;
        if (xfer === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: transfer of ir_pc=0x%0h, expected none", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e || d !== {1'b1, e}) begin
                    n_fail++;
                    $display("FAIL sb_order: got ir_pc=0x%0h ir=0x%0h, expected ir_pc=0x%0h ir=0x%0h",
                             a, d, e, {1'b1, e});
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic h, input logic j,
                         input logic [AW-1:0] ja, input logic rdy);
        rst = r; halt = h; jmp = j; jmp_addr = ja; ir_ready = rdy;
    endtask

    // ---------------- main ----------------
    initial begin
        int xfers;
        n_tests = 0;
        n_fail  = 0;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset state
        tick();
        tick();
        chk("rst_ir",       0, 32'(ir),       32'h0);
        chk("rst_ir_pc",    0, 32'(ir_pc),    32'h0);
        chk("rst_ir_valid", 0, 32'(ir_valid), 32'h0);
        chk("rst_halted",   0, 32'(halted),   32'h0);
        chk("rst_rom_addr", 0, 32'(rom_addr), 32'h0);

        //                r  h  j  ja     rdy  ev ep     erom   eh
        vecs[0]  = mk(1, 1, 1, 8'h55, 0,   0, 8'h00, 8'h00, 0); // rst dominates
        vecs[1]  = mk(0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h01, 0); // stream
        vecs[2]  = mk(0, 0, 0, 8'h00, 1,   1, 8'h01, 8'h02, 0);
        vecs[3]  = mk(0, 0, 0, 8'h00, 1,   1, 8'h02, 8'h03, 0);
        vecs[4]  = mk(0, 0, 0, 8'h00, 1,   1, 8'h03, 8'h04, 0);
        vecs[5]  = mk(0, 0, 0, 8'h00, 1,   1, 8'h04, 8'h05, 0);
        vecs[6]  = mk(0, 0, 0, 8'h00, 1,   1, 8'h05, 8'h06, 0);
        vecs[7]  = mk(0, 0, 0, 8'h00, 0,   1, 8'h05, 8'h06, 0); // stall x3
        vecs[8]  = mk(0, 0, 0, 8'h00, 0,   1, 8'h05, 8'h06, 0);
        vecs[9]  = mk(0, 0, 0, 8'h00, 0,   1, 8'h05, 8'h06, 0);
        vecs[10] = mk(0, 0, 0, 8'h00, 1,   1, 8'h06, 8'h07, 0);
        vecs[11] = mk(0, 0, 1, 8'h40, 1,   0, 8'h00, 8'h40, 0); // jump
        vecs[12] = mk(0, 0, 0, 8'h00, 1,   1, 8'h40, 8'h41, 0);
        vecs[13] = mk(0, 0, 1, 8'hFE, 1,   0, 8'h00, 8'hFE, 0); // wrap
        vecs[14] = mk(0, 0, 0, 8'h00, 1,   1, 8'hFE, 8'hFF, 0);
        vecs[15] = mk(0, 0, 0, 8'h00, 1,   1, 8'hFF, 8'h00, 0);
        vecs[16] = mk(0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h01, 0);
        vecs[17] = mk(0, 0, 0, 8'h00, 1,   1, 8'h01, 8'h02, 0);
        vecs[18] = mk(0, 0, 1, 8'h0A, 1,   0, 8'h00, 8'h0A, 0);
        vecs[19] = mk(0, 0, 0, 8'h00, 1,   1, 8'h0A, 8'h0B, 0);
        vecs[20] = mk(0, 1, 0, 8'h00, 0,   1, 8'h0A, 8'h0B, 1); // halt, pending
        vecs[21] = mk(0, 1, 0, 8'h00, 0,   1, 8'h0A, 8'h0B, 1);
        vecs[22] = mk(0, 1, 0, 8'h00, 1,   0, 8'h00, 8'h0B, 1); // drained
        vecs[23] = mk(0, 0, 0, 8'h00, 1,   0, 8'h00, 8'h0B, 0); // back to RUN
        vecs[24] = mk(0, 0, 0, 8'h00, 1,   1, 8'h0B, 8'h0C, 0); // resume at 11
        vecs[25] = mk(0, 1, 0, 8'h00, 0,   1, 8'h0B, 8'h0C, 1);
        vecs[26] = mk(0, 1, 1, 8'h80, 0,   0, 8'h00, 8'h80, 1); // jmp in HALTED
        vecs[27] = mk(0, 0, 0, 8'h00, 0,   0, 8'h00, 8'h80, 0);
        vecs[28] = mk(0, 0, 0, 8'h00, 1,   1, 8'h80, 8'h81, 0);
        vecs[29] = mk(0, 1, 1, 8'h20, 1,   0, 8'h00, 8'h20, 0); // jmp beats halt
        vecs[30] = mk(0, 1, 0, 8'h00, 1,   0, 8'h00, 8'h20, 1);
        vecs[31] = mk(0, 0, 0, 8'h00, 1,   0, 8'h00, 8'h20, 0);
        vecs[32] = mk(0, 0, 0, 8'h00, 1,   1, 8'h20, 8'h21, 0);
        vecs[33] = mk(0, 0, 0, 8'h00, 0,   1, 8'h20, 8'h21, 0);
        vecs[34] = mk(0, 1, 0, 8'h00, 0,   1, 8'h20, 8'h21, 1);
        vecs[35] = mk(1, 1, 0, 8'h00, 0,   0, 8'h00, 8'h00, 0); // reset mid-stall
        vecs[36] = mk(0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h01, 0);

        // Words the decoder must accept, in order, over the whole table.
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                  8'h40, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h0A, 8'h80};

        for (int i = 0; i < 37; i++) begin
            drive(vecs[i].rst, vecs[i].halt, vecs[i].jmp, vecs[i].ja, vecs[i].rdy);
            tick();
            chk("ir_valid", i, 32'(ir_valid), 32'(vecs[i].e_valid));
            chk("halted",   i, 32'(halted),   32'(vecs[i].e_halt));
            chk("rom_addr", i, 32'(rom_addr), 32'(vecs[i].e_rom));
            if (vecs[i].e_valid) begin
                chk("ir_pc", i, 32'(ir_pc), 32'(vecs[i].e_pc));
                chk("ir",    i, 32'(ir),    32'({1'b1, vecs[i].e_pc}));
            end
        end
        chk("sb_drained", 0, 32'(exp_q.size()), 32'h0);

        // Random backpressure: every accepted word must be the next address.
        exp_q.delete();
        for (int k = 0; k < 48; k++) begin
            exp_q.push_back(8'(8'h10 + k));
        end
        drive(1'b0, 1'b0, 1'b1, 8'h10, 1'b0);
        tick();
        xfers = exp_q.size();
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
            tick();
        end
        xfers = xfers - exp_q.size();
        n_tests++;
        if (xfers < 1 || xfers > 39) begin
            n_fail++;
            $display("FAIL rand_xfers: got %0d transfers, expected 1..39", xfers);
        end
        exp_q.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
